// File: rtl/cell_bist.sv
// BIST driver/checker for combinational library cells: walks every input pattern,
// folds the cell response into a Galois MISR and compares it against a golden signature.
module cell_bist #(
    parameter int              NIN  = 3,
    parameter int              NOUT = 1,
    parameter int              SIGW = 16,
    parameter logic [SIGW-1:0] POLY = 16'hB400,
    parameter logic [SIGW-1:0] SEED = 16'hFFFF
) (
    input  logic            CK,
    input  logic            R,
    input  logic            START,
    input  logic [SIGW-1:0] GOLDEN,
    output logic [NIN-1:0]  STIM,
    input  logic [NOUT-1:0] RESP,
    output logic            BUSY,
    output logic            DONE,
    output logic            PASS,
    output logic [SIGW-1:0] SIG
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] APPLY  = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] FIN    = 2'd3;

    // One extra counter bit keeps the terminal pattern distinct from a wrapped zero.
    localparam logic [NIN:0] LAST = {1'b0, {NIN{1'b1}}};

    logic [1:0]      state_q, state_d;
    logic [NIN:0]    cnt_q, cnt_d;
    logic [SIGW-1:0] sig_q, sig_d;
    logic [SIGW-1:0] gold_q, gold_d;
    logic            pass_q, pass_d;
    logic [SIGW-1:0] sig_step;
    logic            running;

    assign running  = (state_q == APPLY) || (state_q == SAMPLE);
    assign sig_step = {1'b0, sig_q[SIGW-1:1]} ^ (sig_q[0] ? POLY : '0) ^ SIGW'(RESP);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sig_d   = sig_q;
        gold_d  = gold_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    gold_d  = GOLDEN;
                    cnt_d   = '0;
                    sig_d   = SEED;
                    state_d = APPLY;
                end
            end
            APPLY: begin
                state_d = SAMPLE;
            end
            SAMPLE: begin
                sig_d = sig_step;
                if (cnt_q == LAST) begin
                    // Case equality so an unknown response can never report a match.
                    pass_d  = (sig_step === gold_q);
                    state_d = FIN;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = APPLY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CK) begin
        if (R) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sig_q   <= SEED;
            gold_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
            gold_q  <= gold_d;
            pass_q  <= pass_d;
        end
    end

    assign STIM = running ? cnt_q[NIN-1:0] : '0;
    assign BUSY = running;
    assign DONE = (state_q == FIN);
    assign PASS = pass_q;
    assign SIG  = sig_q;

endmodule

// File: tb/tb_cell_bist.sv
// Directed bench for cell_bist: a NAND2 model and an inverter model on two instances.
module tb_cell_bist;

    logic CK = 1'b0;
    always #5 CK = ~CK;

    // nd2 instance
    logic        r2, st2;
    logic [15:0] gold2, sig2;
    logic [1:0]  stim2;
    logic [0:0]  resp2;
    logic        busy2, done2, pass2;
    logic        stuck, xinj;
    logic        xval;

    assign resp2 = xinj ? xval : (stuck ? 1'b1 : ~&stim2);

    cell_bist #(.NIN(2), .NOUT(1), .SIGW(16), .POLY(16'hB400), .SEED(16'hFFFF)) u_nd2 (
        .CK(CK), .R(r2), .START(st2), .GOLDEN(gold2), .STIM(stim2), .RESP(resp2),
        .BUSY(busy2), .DONE(done2), .PASS(pass2), .SIG(sig2)
    );

    // inv instance
    logic        r1, st1;
    logic [15:0] gold1, sig1;
    logic [0:0]  stim1;
    logic [0:0]  resp1;
    logic        busy1, done1, pass1;

    assign resp1 = ~stim1;

    cell_bist #(.NIN(1), .NOUT(1), .SIGW(16), .POLY(16'hB400), .SEED(16'hFFFF)) u_inv (
        .CK(CK), .R(r1), .START(st1), .GOLDEN(gold1), .STIM(stim1), .RESP(resp1),
        .BUSY(busy1), .DONE(done1), .PASS(pass1), .SIG(sig1)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        r;
        logic        start;
        logic [15:0] golden;
        logic [1:0]  stim;
        logic        busy;
        logic        done;
        logic        pass;
        logic [15:0] sig;
    } vec_t;

    vec_t tbl[10];

    task automatic cyc();
        @(posedge CK);
        #1;
    endtask

    // Start a run, then watch a bounded window for DONE pulses.
    task automatic nd2_run(input logic [15:0] g, output logic [15:0] s, output logic p,
                           output int lat, output int ndone);
        st2 = 1'b1; gold2 = g;
        cyc();
        st2 = 1'b0;
        lat = 0; ndone = 0; s = '0; p = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            cyc();
            if (done2) begin
                ndone++;
                if (ndone == 1) begin
                    lat = i; s = sig2; p = pass2;
                end
            end
        end
    endtask

    logic [15:0] s;
    logic        p, exp_p;
    int          lat, nd;

    initial begin
        r2 = 1'b1; st2 = 1'b0; gold2 = '0; stuck = 1'b0; xinj = 1'b0; xval = 1'bx;
        r1 = 1'b1; st1 = 1'b0; gold1 = '0;

        //            r     st    golden    stim  busy  done  pass  sig
        tbl[0] = '{1'b0, 1'b1, 16'h197F, 2'd0, 1'b1, 1'b0, 1'b0, 16'hFFFF};
        tbl[1] = '{1'b0, 1'b0, 16'h197F, 2'd0, 1'b1, 1'b0, 1'b0, 16'hFFFF};
        tbl[2] = '{1'b0, 1'b0, 16'h197F, 2'd1, 1'b1, 1'b0, 1'b0, 16'hCBFE};
        tbl[3] = '{1'b0, 1'b0, 16'h197F, 2'd1, 1'b1, 1'b0, 1'b0, 16'hCBFE};
        tbl[4] = '{1'b0, 1'b0, 16'h197F, 2'd2, 1'b1, 1'b0, 1'b0, 16'h65FE};
        tbl[5] = '{1'b0, 1'b0, 16'h197F, 2'd2, 1'b1, 1'b0, 1'b0, 16'h65FE};
        tbl[6] = '{1'b0, 1'b0, 16'h197F, 2'd3, 1'b1, 1'b0, 1'b0, 16'h32FE};
        tbl[7] = '{1'b0, 1'b0, 16'h197F, 2'd3, 1'b1, 1'b0, 1'b0, 16'h32FE};
        tbl[8] = '{1'b0, 1'b0, 16'h197F, 2'd0, 1'b0, 1'b1, 1'b1, 16'h197F};
        tbl[9] = '{1'b0, 1'b0, 16'h197F, 2'd0, 1'b0, 1'b0, 1'b1, 16'h197F};

        // reset state
        cyc(); cyc();
        chk("rst_stim", 32'(stim2), 0);
        chk("rst_busy", 32'(busy2), 0);
        chk("rst_done", 32'(done2), 0);
        chk("rst_pass", 32'(pass2), 0);
        chk("rst_sig",  32'(sig2), 32'hFFFF);
        chk("rst_inv_sig", 32'(sig1), 32'hFFFF);
        r2 = 1'b0; r1 = 1'b0;

        // nd2 golden run, cycle by cycle
        for (int i = 0; i < 10; i++) begin
            r2 = tbl[i].r; st2 = tbl[i].start; gold2 = tbl[i].golden;
            cyc();
            chk($sformatf("tbl%0d_stim", i), 32'(stim2), 32'(tbl[i].stim));
            chk($sformatf("tbl%0d_busy", i), 32'(busy2), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_done", i), 32'(done2), 32'(tbl[i].done));
            chk($sformatf("tbl%0d_pass", i), 32'(pass2), 32'(tbl[i].pass));
            chk($sformatf("tbl%0d_sig",  i), 32'(sig2),  32'(tbl[i].sig));
        end

        // reset during the second SAMPLE abandons the run
        st2 = 1'b1; gold2 = 16'h197F;
        cyc();
        st2 = 1'b0;
        cyc(); cyc(); cyc();
        chk("mid_pre_stim", 32'(stim2), 1);
        r2 = 1'b1;
        cyc();
        r2 = 1'b0;
        chk("mid_stim", 32'(stim2), 0);
        chk("mid_busy", 32'(busy2), 0);
        chk("mid_sig",  32'(sig2), 32'hFFFF);
        chk("mid_pass", 32'(pass2), 0);
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (done2 || busy2) nd++;
        end
        chk("mid_no_done", 32'(nd), 0);
        nd2_run(16'h197F, s, p, lat, nd);
        chk("fresh_lat",  32'(lat), 8);
        chk("fresh_sig",  32'(s), 32'h197F);
        chk("fresh_pass", 32'(p), 1);
        chk("fresh_ndone", 32'(nd), 1);

        // stuck-at-1 output
        stuck = 1'b1;
        nd2_run(16'h197F, s, p, lat, nd);
        stuck = 1'b0;
        chk("sa1_sig",   32'(s), 32'h197E);
        chk("sa1_pass",  32'(p), 0);
        chk("sa1_ndone", 32'(nd), 1);

        // START held through the run; GOLDEN corrupted after acceptance
        st2 = 1'b1; gold2 = 16'h197F;
        cyc();
        gold2 = 16'h1234;
        lat = 0;
        for (int i = 1; i <= 30 && lat == 0; i++) begin
            cyc();
            if (done2) lat = i;
        end
        chk("hold_lat",  32'(lat), 8);
        chk("hold_pass", 32'(pass2), 1);
        chk("hold_sig",  32'(sig2), 32'h197F);
        cyc();
        chk("hold_idle_busy", 32'(busy2), 0);
        chk("hold_idle_done", 32'(done2), 0);
        cyc();
        chk("hold_rerun_busy", 32'(busy2), 1);
        chk("hold_rerun_sig",  32'(sig2), 32'hFFFF);
        st2 = 1'b0; r2 = 1'b1;
        cyc();
        r2 = 1'b0;

        // unknown response on the first sample (its good value is 1)
        st2 = 1'b1; gold2 = 16'h197F;
        cyc();
        st2 = 1'b0; xinj = 1'b1;
        cyc(); cyc();
        xinj = 1'b0;
        exp_p = (xval === 1'b1);
        lat = 0;
        for (int i = 3; i <= 30 && lat == 0; i++) begin
            cyc();
            if (done2) lat = i;
        end
        chk("x_lat",  32'(lat), 8);
        chk("x_pass", 32'(pass2), 32'(exp_p));

        // inverter bench
        st1 = 1'b1; gold1 = 16'h65FF;
        cyc();
        st1 = 1'b0;
        chk("inv_a0_stim", 32'(stim1), 0);
        chk("inv_a0_busy", 32'(busy1), 1);
        cyc(); cyc();
        chk("inv_a1_stim", 32'(stim1), 1);
        chk("inv_a1_sig",  32'(sig1), 32'hCBFE);
        cyc(); cyc();
        chk("inv_done", 32'(done1), 1);
        chk("inv_busy", 32'(busy1), 0);
        chk("inv_pass", 32'(pass1), 1);
        chk("inv_sig",  32'(sig1), 32'h65FF);
        cyc();
        chk("inv_done_once", 32'(done1), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
